// File: rtl/bcd_tick_counter.sv
// Two-digit BCD counter advanced by rising edges of a slow square wave sampled in the clk domain.
// Optional macro LEADING_ZERO_BLANK_EN blanks the tens display when the tens digit is zero.
module bcd_tick_counter #(
  parameter int unsigned MAX_COUNT = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       slow_clk,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [6:0] load_val,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [6:0] seg_ones,
  output logic [6:0] seg_tens,
  output logic       wrap
);

  localparam logic [6:0] MAX_BIN  = 7'(MAX_COUNT);
  localparam logic [3:0] MAX_TENS = 4'(MAX_COUNT / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_COUNT % 10);

  // Active-low segments {g,f,e,d,c,b,a}; non-decimal codes show nothing.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  logic       slow_q;
  logic       tick;
  logic       at_max;
  logic       at_zero;
  logic [6:0] load_clamped;
  logic [7:0] load_bcd;
  logic [3:0] ones_d;
  logic [3:0] tens_d;
  logic       wrap_d;

  // slow_clk is plain data here; a rising edge is a 0 last cycle and a 1 now.
  assign tick = slow_clk & ~slow_q;

  assign at_max  = (tens == MAX_TENS) && (ones == MAX_ONES);
  assign at_zero = (tens == 4'd0) && (ones == 4'd0);

  // Clamp first so the packed {tens,ones} result always fits two decimal digits.
  assign load_clamped = (load_val > MAX_BIN) ? MAX_BIN : load_val;
  assign load_bcd     = 8'((32'(load_clamped) / 10) * 16 + (32'(load_clamped) % 10));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    ones_d = ones;
    tens_d = tens;
    wrap_d = 1'b0;

    if (load) begin
      tens_d = load_bcd[7:4];
      ones_d = load_bcd[3:0];
    end else if (tick && en) begin
      if (up) begin
        if (at_max) begin
          ones_d = 4'd0;
          tens_d = 4'd0;
          wrap_d = 1'b1;
        end else if (ones == 4'd9) begin
          ones_d = 4'd0;
          tens_d = tens + 4'd1;
        end else begin
          ones_d = ones + 4'd1;
        end
      end else begin
        if (at_zero) begin
          ones_d = MAX_ONES;
          tens_d = MAX_TENS;
          wrap_d = 1'b1;
        end else if (ones == 4'd0) begin
          ones_d = 4'd9;
          tens_d = tens - 4'd1;
        end else begin
          ones_d = ones - 4'd1;
        end
      end
    end
  end

  // Reset still samples slow_clk so a level already high at release is not seen as an edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) begin
      slow_q <= slow_clk;
      ones   <= 4'd0;
      tens   <= 4'd0;
      wrap   <= 1'b0;
    end else begin
      slow_q <= slow_clk;
      ones   <= ones_d;
      tens   <= tens_d;
      wrap   <= wrap_d;
    end
  end

  assign seg_ones = seg_decode(ones);

`ifdef LEADING_ZERO_BLANK_EN
  assign seg_tens = (tens == 4'd0) ? 7'h7F : seg_decode(tens);
`else
  assign seg_tens = seg_decode(tens);
`endif

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Randomized and directed bench for bcd_tick_counter against an integer-count reference model.
module tb_bcd_tick_counter;

  localparam int MAX_COUNT = 59;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       slow_clk;
  logic       en;
  logic       up;
  logic       load;
  logic [6:0] load_val;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [6:0] seg_ones;
  logic [6:0] seg_tens;
  logic       wrap;

  bcd_tick_counter #(.MAX_COUNT(MAX_COUNT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .slow_clk (slow_clk),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .ones     (ones),
    .tens     (tens),
    .seg_ones (seg_ones),
    .seg_tens (seg_tens),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: the count as a plain integer, last sampled slow level, expected wrap.
  int   model_cnt  = 0;
  logic model_prev = 1'b0;
  logic model_wrap = 1'b0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [6:0] seg_ref(input int d);
    logic [6:0] table_v [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return table_v[d];
  endfunction

  // One clk cycle: apply inputs, let the edge happen, advance the model, compare outputs.
  task automatic drive(input logic r, input logic s, input logic e, input logic u,
                       input logic l, input logic [6:0] lv, input logic do_check);
    logic       tick;
    logic [6:0] exp_seg_tens;
    rst_n = r; slow_clk = s; en = e; up = u; load = l; load_val = lv;
    @(posedge clk);
    if (!r) begin
      model_cnt  = 0;
      model_wrap = 1'b0;
      model_prev = s;
    end else begin
      tick       = s & ~model_prev;
      model_prev = s;
      model_wrap = 1'b0;
      if (l) begin
        model_cnt = (int'(lv) > MAX_COUNT) ? MAX_COUNT : int'(lv);
      end else if (tick && e) begin
        if (u) begin
          if (model_cnt == MAX_COUNT) begin model_cnt = 0; model_wrap = 1'b1; end
          else model_cnt++;
        end else begin
          if (model_cnt == 0) begin model_cnt = MAX_COUNT; model_wrap = 1'b1; end
          else model_cnt--;
        end
      end
    end
    #1;
    if (do_check) begin
`ifdef LEADING_ZERO_BLANK_EN
      exp_seg_tens = (model_cnt / 10 == 0) ? 7'h7F : seg_ref(model_cnt / 10);
`else
      exp_seg_tens = seg_ref(model_cnt / 10);
`endif
      check("ones",     32'(ones),     32'(model_cnt % 10));
      check("tens",     32'(tens),     32'(model_cnt / 10));
      check("wrap",     32'(wrap),     32'(model_wrap));
      check("seg_ones", 32'(seg_ones), 32'(seg_ref(model_cnt % 10)));
      check("seg_tens", 32'(seg_tens), 32'(exp_seg_tens));
    end
  endtask

  // A full slow_clk period: high for hi cycles, then low for two.
  task automatic slow_pulse(input logic e, input logic u, input int hi);
    for (int i = 0; i < hi; i++) drive(1'b1, 1'b1, e, u, 1'b0, 7'd0, 1'b1);
    for (int i = 0; i < 2; i++)  drive(1'b1, 1'b0, e, u, 1'b0, 7'd0, 1'b1);
  endtask

  logic r_s, s_s, e_s, u_s, l_s;

  initial begin
    // Reset with slow_clk high, then hold it high after release: no tick may appear.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 7'd0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 7'd0, 1'b1);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 7'd0, 1'b1);
    check("no_tick_after_reset", 32'(ones), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 1'b1);

    // 60 rising edges counting up: full sequence, 09->10 carry, 59->00 wrap.
    for (int n = 0; n < 60; n++) begin
      slow_pulse(1'b1, 1'b1, 1 + (n % 3));
      if (n == 9) check("carry_to_10", 32'({tens, ones}), 32'h10);
    end
    check("wrapped_to_00", 32'({tens, ones}), 32'h00);

    // Down from 00 wraps to 59, then 58.
    slow_pulse(1'b1, 1'b0, 1);
    check("down_wrap_59", 32'({tens, ones}), 32'h59);
    slow_pulse(1'b1, 1'b0, 1);
    check("down_58", 32'({tens, ones}), 32'h58);

    // Load coincident with a rising edge: the tick is discarded.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 7'd42, 1'b1);
    check("load_42", 32'({tens, ones}), 32'h42);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 7'd100, 1'b1);
    check("load_clamp", 32'({tens, ones}), 32'h59);

    // Enable low across five edges at 17, then one enabled edge.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 7'd17, 1'b1);
    for (int n = 0; n < 5; n++) slow_pulse(1'b0, 1'b1, 1);
    check("en_hold_17", 32'({tens, ones}), 32'h17);
    slow_pulse(1'b1, 1'b1, 1);
    check("en_resume_18", 32'({tens, ones}), 32'h18);

    // Long high time gives a single increment.
    slow_pulse(1'b1, 1'b1, 20);
    check("long_high_19", 32'({tens, ones}), 32'h19);

    // Reset at 35 overrides a coincident tick.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 7'd35, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 7'd0, 1'b1);
    check("reset_mid", 32'({tens, ones}), 32'h00);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 7'd0, 1'b1);

    // Random traffic against the model.
    s_s = 1'b1; u_s = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(2) == 0) s_s = ~s_s;
      if ($urandom_range(40) == 0) u_s = ~u_s;
      e_s = ($urandom_range(7) != 0);
      l_s = ($urandom_range(63) == 0);
      r_s = ($urandom_range(299) != 0);
      drive(r_s, s_s, e_s, u_s, l_s, 7'($urandom_range(127)), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
